// File: rtl/fp_align_pipe.sv
// rtl/fp_align_pipe.sv - two-stage operand alignment pipeline for the FP adder
//
// Orders two unpacked operands by magnitude (stage 1) and right-shifts the
// smaller mantissa onto the larger exponent with guard/round/sticky (stage 2).
// Fixed 2-cycle latency, valid/ready on both sides, 1 op/cycle throughput.
//
// Optional build macro: FP_ALIGN_STATS_EN adds a saturating counter of output
// transfers that carried full_shift=1 (ports stats_clr / stats_full_shift_cnt).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake for one operand pair
//   sign_*, exp_*, mant_*  operand m and n (mantissa includes hidden bit)
//   out_valid / out_ready  output handshake
//   aligned_mantissa       {shifted small mantissa, guard, round, sticky}
//   big_exponent           exponent of larger-magnitude operand
//   big_mantissa           mantissa of larger-magnitude operand
//   final_sign             sign of larger-magnitude operand
//   operation              sign_m ^ sign_n (1 = effective subtract)
//   full_shift             small operand shifted entirely into sticky
//   stats_clr              (macro only) synchronous clear of the counter
//   stats_full_shift_cnt   (macro only) saturating full-shift counter

module fp_align_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign_m,
  input  logic                 sign_n,
  input  logic [EXP_W-1:0]     exp_m,
  input  logic [EXP_W-1:0]     exp_n,
  input  logic [MAN_W:0]       mant_m,
  input  logic [MAN_W:0]       mant_n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_W+3:0]     aligned_mantissa,
  output logic [EXP_W-1:0]     big_exponent,
  output logic [MAN_W:0]       big_mantissa,
  output logic                 final_sign,
  output logic                 operation,
  output logic                 full_shift
`ifdef FP_ALIGN_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [15:0]          stats_full_shift_cnt
`endif
);

  localparam int W = MAN_W + 1;

  // Pipeline control
  logic init_done;  // holds off in_ready for the first cycle after reset
  logic s1_valid;
  logic s2_valid;
  logic s1_advance;

  assign out_valid  = s2_valid;
  assign s1_advance = ~s2_valid | out_ready;
  assign in_ready   = init_done & (~s1_valid | s1_advance);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (in_ready) s1_valid <= in_valid;
      if (s1_advance) s2_valid <= s1_valid;
    end
  end

  // Stage 1: compare / swap
  logic             m_big;
  logic [EXP_W-1:0] diff_d;

  // Ties (equal exponent and mantissa) select m.
  assign m_big = (exp_m > exp_n) || ((exp_m == exp_n) && !(mant_n > mant_m));

  // Operands are already ordered, so the subtraction never wraps.
  assign diff_d = m_big ? (exp_m - exp_n) : (exp_n - exp_m);

  logic             s1_sign;
  logic             s1_op;
  logic [EXP_W-1:0] s1_exp;
  logic [W-1:0]     s1_big;
  logic [W-1:0]     s1_lil;
  logic [EXP_W-1:0] s1_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign <= 1'b0;
      s1_op   <= 1'b0;
      s1_exp  <= '0;
      s1_big  <= '0;
      s1_lil  <= '0;
      s1_diff <= '0;
    end else if (in_valid && in_ready) begin
      s1_sign <= m_big ? sign_m : sign_n;
      s1_op   <= sign_m ^ sign_n;
      s1_exp  <= m_big ? exp_m : exp_n;
      s1_big  <= m_big ? mant_m : mant_n;
      s1_lil  <= m_big ? mant_n : mant_m;
      s1_diff <= diff_d;
    end
  end

  // Stage 2: shift / GRS
  logic [2*W+1:0] shift_src;
  logic [2*W+1:0] shift_vec;
  logic           full_d;
  logic [W+2:0]   aligned_d;

  assign shift_src = {s1_lil, {(W+2){1'b0}}};

  always_comb begin
    full_d = (32'(s1_diff) >= 32'(W + 2));
    // Shift amount saturates at W+2: the whole mantissa then sits in the
    // sticky window and guard/round are zero.
    if (full_d) shift_vec = shift_src >> (W + 2);
    else        shift_vec = shift_src >> s1_diff;
    aligned_d = {shift_vec[2*W+1:W+2], shift_vec[W+1], shift_vec[W], |shift_vec[W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aligned_mantissa <= '0;
      big_exponent     <= '0;
      big_mantissa     <= '0;
      final_sign       <= 1'b0;
      operation        <= 1'b0;
      full_shift       <= 1'b0;
    end else if (s1_valid && s1_advance) begin
      aligned_mantissa <= aligned_d;
      big_exponent     <= s1_exp;
      big_mantissa     <= s1_big;
      final_sign       <= s1_sign;
      operation        <= s1_op;
      full_shift       <= full_d;
    end
  end

`ifdef FP_ALIGN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_full_shift_cnt <= '0;
    end else if (stats_clr) begin
      stats_full_shift_cnt <= '0;
    end else if (out_valid && out_ready && full_shift && (stats_full_shift_cnt != 16'hFFFF)) begin
      stats_full_shift_cnt <= stats_full_shift_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_align_pipe.sv
// tb/tb_fp_align_pipe.sv - scoreboard bench for fp_align_pipe

module tb_fp_align_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = MAN_W + 1;

  typedef struct packed {
    logic [W+2:0]     al;
    logic [EXP_W-1:0] be;
    logic [W-1:0]     bm;
    logic             fs;
    logic             op;
    logic             full;
  } res_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             sign_m, sign_n;
  logic [EXP_W-1:0] exp_m, exp_n;
  logic [W-1:0]     mant_m, mant_n;
  logic             out_valid;
  logic             out_ready;
  logic [W+2:0]     aligned_mantissa;
  logic [EXP_W-1:0] big_exponent;
  logic [W-1:0]     big_mantissa;
  logic             final_sign;
  logic             operation;
  logic             full_shift;
`ifdef FP_ALIGN_STATS_EN
  logic             stats_clr;
  logic [15:0]      stats_full_shift_cnt;
`endif

  fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_m(sign_m), .sign_n(sign_n),
    .exp_m(exp_m), .exp_n(exp_n),
    .mant_m(mant_m), .mant_n(mant_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .aligned_mantissa(aligned_mantissa), .big_exponent(big_exponent),
    .big_mantissa(big_mantissa), .final_sign(final_sign),
    .operation(operation), .full_shift(full_shift)
`ifdef FP_ALIGN_STATS_EN
    , .stats_clr(stats_clr), .stats_full_shift_cnt(stats_full_shift_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  res_t sb[$];
  int   exp_full_cnt = 0;

  // out_ready policy: 0 = always 1, 1 = random, 2 = low during phase cycles 3..6, 3 = always 0
  int   or_mode   = 0;
  int   phase_cyc = 0;
  int   not_ready_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: magnitude ordering on the real value, GRS from the bits shifted out.
  function automatic res_t model(input logic sm, input int em, input int mm,
                                 input logic sn, input int en, input int mn);
    res_t r;
    int vm, vn, big_e, big_m, lil, diff, sh, g, rb, s;
    bit pick_m;
    vm = em * (1 << W) + mm;
    vn = en * (1 << W) + mn;
    pick_m = (vm >= vn);
    big_e = pick_m ? em : en;
    big_m = pick_m ? mm : mn;
    lil   = pick_m ? mn : mm;
    diff  = (em > en) ? em - en : en - em;
    sh    = (diff < W + 2) ? diff : W + 2;
    g  = (sh >= 1) ? (lil >> (sh - 1)) & 1 : 0;
    rb = (sh >= 2) ? (lil >> (sh - 2)) & 1 : 0;
    s  = (sh >= 3) ? ((lil % (1 << (sh - 2))) != 0) : 0;
    r.al   = (W+3)'((lil >> sh) * 8 + g * 4 + rb * 2 + s);
    r.be   = EXP_W'(big_e);
    r.bm   = W'(big_m);
    r.fs   = pick_m ? sm : sn;
    r.op   = sm ^ sn;
    r.full = (diff >= W + 2);
    return r;
  endfunction

  function automatic logic next_out_ready();
    case (or_mode)
      0: return 1'b1;
      1: return ($urandom % 4) != 0;
      2: return !(phase_cyc >= 3 && phase_cyc <= 6);
      default: return 1'b0;
    endcase
  endfunction

  // Present one operand pair until accepted; push the expected result on accept.
  task automatic send(input logic sm, input int em, input int mm,
                      input logic sn, input int en, input int mn,
                      input bit use_exp, input res_t exp_r);
    int tries = 0;
    bit acc = 0;
    while (!acc) begin
      @(negedge clk);
      phase_cyc++;
      in_valid = 1'b1;
      sign_m = sm; exp_m = EXP_W'(em); mant_m = W'(mm);
      sign_n = sn; exp_n = EXP_W'(en); mant_n = W'(mn);
      out_ready = next_out_ready();
      #1;
      if (in_ready) begin
        sb.push_back(use_exp ? exp_r : model(sm, em, mm, sn, en, mn));
        acc = 1;
      end else begin
        not_ready_seen++;
        tries++;
        if (tries > 200) begin
          check("send_timeout", 32'(tries), 32'd0);
          acc = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      phase_cyc++;
      in_valid = 1'b0;
      out_ready = next_out_ready();
    end
  endtask

  task automatic drain();
    int c = 0;
    or_mode = 0;
    while (sb.size() != 0 && c < 100) begin
      idle(1);
      c++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops on every output transfer, and checks stability across stalls.
  res_t prev_out;
  bit   prev_stall = 0;
  always @(negedge clk) begin
    res_t cur, e;
    #2;
    cur = '{al: aligned_mantissa, be: big_exponent, bm: big_mantissa,
            fs: final_sign, op: operation, full: full_shift};
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_data_held", 32'(cur), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(cur), 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", 32'(cur), 32'(e));
          if (e.full) exp_full_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = cur;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    res_t r;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign_m = 0; sign_n = 0; exp_m = '0; exp_n = '0; mant_m = '0; mant_n = '0;
`ifdef FP_ALIGN_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_aligned", 32'(aligned_mantissa), 32'd0);
    check("rst_big_exp", 32'(big_exponent), 32'd0);
    check("rst_big_mant", 32'(big_mantissa), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors with hand-derived results
    or_mode = 0;
    r = '{al: 14'h0C00, be: 5'd15, bm: 11'h400, fs: 1'b0, op: 1'b1, full: 1'b0};
    send(0, 15, 'h400, 1, 13, 'h600, 1, r);
    r = '{al: 14'h1004, be: 5'd11, bm: 11'h400, fs: 1'b0, op: 1'b0, full: 1'b0};
    send(0, 10, 'h401, 0, 11, 'h400, 1, r);
    r = '{al: 14'h0001, be: 5'd23, bm: 11'h7FF, fs: 1'b0, op: 1'b0, full: 1'b1};
    send(0, 3, 'h401, 0, 23, 'h7FF, 1, r);
    r = '{al: 14'h2400, be: 5'd7, bm: 11'h500, fs: 1'b1, op: 1'b1, full: 1'b0};
    send(0, 7, 'h480, 1, 7, 'h500, 1, r);
    r = '{al: 14'h2400, be: 5'd7, bm: 11'h480, fs: 1'b0, op: 1'b1, full: 1'b0};
    send(0, 7, 'h480, 1, 7, 'h480, 1, r);
    drain();

    // Six back-to-back inputs with out_ready low for phase cycles 3..6
    or_mode = 2; phase_cyc = 0; not_ready_seen = 0;
    for (int i = 0; i < 6; i++)
      send(1'($urandom), 8 + i, 'h400 | (i * 37), 1'($urandom), 6 + 2 * i, 'h400 | (i * 91), 0, r);
    check("in_ready_dropped", 32'(not_ready_seen > 0), 32'd1);
    drain();

    // Randomised traffic with random backpressure and input gaps
    or_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int em, en;
      em = $urandom % 32;
      en = ($urandom % 4 == 0) ? em : $urandom % 32;
      send(1'($urandom), em, 'h400 | ($urandom % 1024),
           1'($urandom), en, ($urandom % 8 == 0) ? 'h400 : ('h400 | ($urandom % 1024)), 0, r);
      if ($urandom % 5 == 0) idle($urandom % 3);
    end
    drain();

`ifdef FP_ALIGN_STATS_EN
    idle(1);
    check("stats_cnt", 32'(stats_full_shift_cnt), 32'(exp_full_cnt));
`endif

    // Reset with both stages full
    or_mode = 3;
    send(0, 20, 'h555, 0, 2, 'h7FF, 0, r);
    send(1, 9, 'h6AA, 0, 12, 'h401, 0, r);
    @(negedge clk); in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_aligned", 32'(aligned_mantissa), 32'd0);
    check("midrst_big_mant", 32'(big_mantissa), 32'd0);
    sb.delete();
    exp_full_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_midrst", 32'(in_ready), 32'd1);
    or_mode = 0;
    send(0, 15, 'h400, 1, 13, 'h600, 0, r);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    #1 check("latency_t1_not_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check("latency_t2_valid", 32'(out_valid), 32'd1);
    drain();
`ifdef FP_ALIGN_STATS_EN
    idle(1);
    check("stats_cnt_after_rst", 32'(stats_full_shift_cnt), 32'(exp_full_cnt));
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, pipelined operand-alignment stage for the floating-point adder datapath.
- Takes two unpacked operands (sign, biased exponent, mantissa with hidden bit), orders them by magnitude, and right-shifts the smaller mantissa to the larger exponent with guard/round/sticky generation.
- Sits between operand unpack and the add/subtract stage; fixed 2-cycle latency, valid/ready handshake on both sides, full throughput of 1 operation per cycle.

Parameters:
- EXP_W, 5, exponent width in bits.
- MAN_W, 10, stored fraction width; internal mantissa width W = MAN_W+1 including the hidden bit.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- sign_m, sign_n  in  1 each  operand signs.
- exp_m, exp_n  in  EXP_W each  biased exponents.
- mant_m, mant_n  in  W each  mantissas including hidden bit.
- out_valid  out  1  output result valid.
- out_ready  in  1  downstream accepts the result this cycle.
- aligned_mantissa  out  W+3  {shifted small mantissa[W], guard, round, sticky}.
- big_exponent  out  EXP_W  exponent of the larger-magnitude operand.
- big_mantissa  out  W  mantissa of the larger-magnitude operand.
- final_sign  out  1  sign of the larger-magnitude operand.
- operation  out  1  sign_m ^ sign_n; 1 means effective subtract.
- full_shift  out  1  small operand was shifted entirely into the sticky region.

Behaviour:
- Reset (async, rst_n=0): both stage valids clear and out_valid=0. All data outputs reset to 0. in_ready=1 one cycle after rst_n deasserts. Reset mid-operation discards in-flight data with no output.
- Transfer occurs in a cycle where valid and ready are both high. An input accepted in cycle t appears with out_valid=1 in cycle t+2 if not stalled.
- Stage 1 (compare/swap), registered:
  - Larger operand selection: exp_m>exp_n selects m. exp_n>exp_m selects n. On equal exponents, mant_n>mant_m selects n; otherwise m, so ties select m.
  - Capture big sign/exp/mant, the small mantissa, operation, and diff = |exp_m-exp_n| (EXP_W bits, no wrap, computed at EXP_W+1 width).
- Stage 2 (shift/GRS), registered:
  - sh = min(diff, W+2).
  - Form a 2W+2 bit vector {lil, (W+2) zeros} and shift it right logically by sh.
  - Top W bits are the shifted mantissa, next bit is guard, next is round. sticky = OR of the low W bits.
  - full_shift = (diff >= W+2).
  - diff=0 gives aligned_mantissa = {lil,3'b000}.
- Pipeline control:
  - Stage 2 holds while out_valid & ~out_ready. Outputs stay stable during the stall.
  - Stage 1 advances when stage 2 is empty or stage 2 is draining this cycle.
  - in_ready = ~s1_valid | s1_advance, combinational from out_ready. No bubbles at steady state; no data is lost or duplicated under any stall pattern.
- Simultaneous accept and drain in the same cycle is a normal case: both stages update.
- Data registers load only on stage advance; they do not load when valid is low.

Optional Feature:
- Macro FP_ALIGN_STATS_EN.
- With the macro defined:
  - Adds input stats_clr (1) and output stats_full_shift_cnt (16).
  - The counter increments by 1 on each output transfer with full_shift=1 and saturates at 16'hFFFF.
  - stats_clr=1 forces the counter to 0 next cycle, with priority over increment.
  - The counter resets to 0 on rst_n.
- Without the macro: neither port exists and there is no counter logic.

Test Plan (defaults, W=11):
1. exp_m=15, mant_m=0x400, exp_n=13, mant_n=0x600, signs 0/1, out_ready=1 -> 2 cycles later: aligned_mantissa=0x0C00, big_exponent=15, big_mantissa=0x400, final_sign=0, operation=1, full_shift=0.
2. exp_m=10, mant_m=0x401, exp_n=11, mant_n=0x400 -> big=n, aligned_mantissa=0x1004 (shifted 0x200, G=1, R=0, S=0), big_exponent=11.
3. exp_m=3, mant_m=0x401, exp_n=23, mant_n=0x7FF -> sh saturates at 13, aligned_mantissa=0x0001, full_shift=1. With FP_ALIGN_STATS_EN the counter reads 1.
4. Equal exponents 7/7, mant_m=0x480, mant_n=0x500, sign_n=1 -> big_mantissa=0x500, final_sign=1, aligned_mantissa=0x2400. Repeat with mant_n=0x480: m is selected.
5. Stream of 6 back-to-back inputs while out_ready is held low for cycles 3-6 -> in_ready drops after 2 accepts, outputs hold stable, all 6 results emerge in order with no loss or duplication; throughput returns to 1 per cycle once out_ready=1.
6. Assert rst_n=0 with both stages valid -> out_valid=0 and outputs 0 immediately; after release, in_ready=1 and the first new result appears 2 cycles after its accept.
